// File: rtl/alu_arbiter_if.sv
// Requester-side handshake bundle for alu_arbiter: one operation request
// channel and one result response channel per requester.
interface alu_arbiter_if #(
    parameter int DW   = 32,
    parameter int SELW = 4
);
    logic            req_valid;
    logic            req_ready;
    logic [DW-1:0]   req_opA;
    logic [DW-1:0]   req_opB;
    logic [SELW-1:0] req_sel;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_result;

    modport master (
        output req_valid, req_opA, req_opB, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_opA, req_opB, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one combinational ALU, one-entry response slot per requester.
// Define ALU_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins); default is round-robin.
module alu_arbiter #(
    parameter int DW   = 32,
    parameter int SELW = 4
) (
    input  logic            clk,
    input  logic            rst,
    alu_arbiter_if.slave    req0,
    alu_arbiter_if.slave    req1,
    output logic [DW-1:0]   alu_opA,
    output logic [DW-1:0]   alu_opB,
    output logic [SELW-1:0] alu_sel,
    input  logic [DW-1:0]   alu_out
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_t;

    slot_t           r_slot0_p1;
    slot_t           r_slot1_p1;
    logic [DW-1:0]   r_res0_p1;
    logic [DW-1:0]   r_res1_p1;

    logic            w_free0;
    logic            w_free1;
    logic            w_elig0;
    logic            w_elig1;
    logic            w_gnt0;
    logic            w_gnt1;

    // A full slot being drained this cycle can accept a new result on the same edge.
    assign w_free0 = (r_slot0_p1 == S_EMPTY) || req0.rsp_ready;
    assign w_free1 = (r_slot1_p1 == S_EMPTY) || req1.rsp_ready;
    assign w_elig0 = !rst && req0.req_valid && w_free0;
    assign w_elig1 = !rst && req1.req_valid && w_free1;

`ifdef ALU_ARB_FIXED_PRI_EN
    assign w_gnt0 = w_elig0;
    assign w_gnt1 = w_elig1 && !w_elig0;
`else
    logic r_last_gnt;

    // r_last_gnt = 1 means requester 1 was served last, so requester 0 wins a tie.
    assign w_gnt0 = w_elig0 && (!w_elig1 || r_last_gnt);
    assign w_gnt1 = w_elig1 && !w_gnt0;
`endif

    assign req0.req_ready  = w_gnt0;
    assign req1.req_ready  = w_gnt1;
    assign req0.rsp_valid  = (r_slot0_p1 == S_FULL);
    assign req1.rsp_valid  = (r_slot1_p1 == S_FULL);
    assign req0.rsp_result = r_res0_p1;
    assign req1.rsp_result = r_res1_p1;

    always_comb begin
        alu_opA = '0;
        alu_opB = '0;
        alu_sel = '0;
        if (w_gnt0) begin
            alu_opA = req0.req_opA;
            alu_opB = req0.req_opB;
            alu_sel = req0.req_sel;
        end else if (w_gnt1) begin
            alu_opA = req1.req_opA;
            alu_opB = req1.req_opB;
            alu_sel = req1.req_sel;
        end
    end

    // p0 -> p1: ALU result captured into the granted requester's slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot0_p1 <= S_EMPTY;
            r_slot1_p1 <= S_EMPTY;
            r_res0_p1  <= '0;
            r_res1_p1  <= '0;
`ifndef ALU_ARB_FIXED_PRI_EN
            r_last_gnt <= 1'b1;
`endif
        end else begin
            if (w_gnt0) begin
                r_slot0_p1 <= S_FULL;
                r_res0_p1  <= alu_out;
            end else if ((r_slot0_p1 == S_FULL) && req0.rsp_ready) begin
                r_slot0_p1 <= S_EMPTY;
            end
            if (w_gnt1) begin
                r_slot1_p1 <= S_FULL;
                r_res1_p1  <= alu_out;
            end else if ((r_slot1_p1 == S_FULL) && req1.rsp_ready) begin
                r_slot1_p1 <= S_EMPTY;
            end
`ifndef ALU_ARB_FIXED_PRI_EN
            if (w_gnt0 || w_gnt1) begin
                r_last_gnt <= w_gnt1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a per-requester result scoreboard.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] alu_opA;
    logic [31:0] alu_opB;
    logic [3:0]  alu_sel;
    logic [31:0] alu_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    alu_arbiter_if #(.DW(32), .SELW(4)) u_if0 ();
    alu_arbiter_if #(.DW(32), .SELW(4)) u_if1 ();

    alu_arbiter #(.DW(32), .SELW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (u_if0),
        .req1    (u_if1),
        .alu_opA (alu_opA),
        .alu_opB (alu_opB),
        .alu_sel (alu_sel),
        .alu_out (alu_out)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] s);
        case (s)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0100: return a & b;
            4'b1000: return a >> b[4:0];
            default: return a ^ b;
        endcase
    endfunction

    assign alu_out = alu_ref(alu_opA, alu_opB, alu_sel);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst) begin
            chk("mon_rst_rdy0", 32'(u_if0.req_ready), 32'd0);
            chk("mon_rst_rdy1", 32'(u_if1.req_ready), 32'd0);
            chk("mon_rst_alu", alu_opA | alu_opB | 32'(alu_sel), 32'd0);
            q0.delete();
            q1.delete();
        end else begin
            chk("mon_one_hot", 32'(u_if0.req_ready & u_if1.req_ready), 32'd0);
            chk("mon_vld0", 32'(u_if0.rsp_valid), 32'(q0.size() != 0));
            chk("mon_vld1", 32'(u_if1.rsp_valid), 32'(q1.size() != 0));
            if (u_if0.rsp_valid && u_if0.rsp_ready && q0.size() != 0) begin
                e = q0.pop_front();
                chk("sb_res0", u_if0.rsp_result, e);
            end
            if (u_if1.rsp_valid && u_if1.rsp_ready && q1.size() != 0) begin
                e = q1.pop_front();
                chk("sb_res1", u_if1.rsp_result, e);
            end
            if (u_if0.req_ready) begin
                chk("mon_alu_a0", alu_opA, u_if0.req_opA);
                chk("mon_alu_s0", 32'(alu_sel), 32'(u_if0.req_sel));
                if (u_if0.req_valid) q0.push_back(alu_ref(u_if0.req_opA, u_if0.req_opB, u_if0.req_sel));
            end else if (u_if1.req_ready) begin
                chk("mon_alu_a1", alu_opA, u_if1.req_opA);
                chk("mon_alu_s1", 32'(alu_sel), 32'(u_if1.req_sel));
                if (u_if1.req_valid) q1.push_back(alu_ref(u_if1.req_opA, u_if1.req_opB, u_if1.req_sel));
            end else begin
                chk("mon_alu_idle", alu_opA | alu_opB | 32'(alu_sel), 32'd0);
            end
        end
    end

    initial begin
        logic exp1;
`ifdef ALU_ARB_FIXED_PRI_EN
        logic fixed = 1'b1;
`else
        logic fixed = 1'b0;
`endif
        rst = 1'b1;
        u_if0.req_valid = 1'b1; u_if0.req_opA = 32'd1; u_if0.req_opB = 32'd1; u_if0.req_sel = 4'd0;
        u_if1.req_valid = 1'b1; u_if1.req_opA = 32'd2; u_if1.req_opB = 32'd2; u_if1.req_sel = 4'd0;
        u_if0.rsp_ready = 1'b1; u_if1.rsp_ready = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_rdy0", 32'(u_if0.req_ready), 32'd0);
        chk("rst_rdy1", 32'(u_if1.req_ready), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        nxt();
        @(negedge clk);
        chk("rst_vld0", 32'(u_if0.rsp_valid), 32'd0);
        chk("rst_vld1", 32'(u_if1.rsp_valid), 32'd0);
        chk("rst_res0", u_if0.rsp_result, 32'd0);
        chk("rst_res1", u_if1.rsp_result, 32'd0);
        nxt();
        rst = 1'b0;
        u_if0.req_valid = 1'b0; u_if1.req_valid = 1'b0;

        // single op: 5 + 3
        u_if0.req_valid = 1'b1; u_if0.req_opA = 32'd5; u_if0.req_opB = 32'd3; u_if0.req_sel = 4'b0000;
        @(negedge clk);
        chk("single_rdy0", 32'(u_if0.req_ready), 32'd1);
        chk("single_rdy1", 32'(u_if1.req_ready), 32'd0);
        chk("single_alu_a", alu_opA, 32'd5);
        nxt();
        u_if0.req_valid = 1'b0;
        @(negedge clk);
        chk("single_vld0", 32'(u_if0.rsp_valid), 32'd1);
        chk("single_res0", u_if0.rsp_result, 32'd8);
        nxt();

        // contention: requester 0 served last, so requester 1 leads in round-robin
        u_if0.req_valid = 1'b1; u_if0.req_opA = 32'd10;  u_if0.req_opB = 32'd4;    u_if0.req_sel = 4'b0001;
        u_if1.req_valid = 1'b1; u_if1.req_opA = 32'hF0;  u_if1.req_opB = 32'h3C;   u_if1.req_sel = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp1 = fixed ? 1'b0 : ((k % 2) == 0);
            chk("cont_rdy0", 32'(u_if0.req_ready), 32'(!exp1));
            chk("cont_rdy1", 32'(u_if1.req_ready), 32'(exp1));
            if (k == 5) begin
                chk("cont_res0", u_if0.rsp_result, 32'd6);
                if (!fixed) chk("cont_res1", u_if1.rsp_result, 32'h30);
            end
            nxt();
        end

        // backpressure on requester 0; requester 1 keeps getting every cycle
        u_if0.rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_rdy0", 32'(u_if0.req_ready), 32'd0);
            chk("bp_rdy1", 32'(u_if1.req_ready), 32'd1);
            chk("bp_vld0", 32'(u_if0.rsp_valid), 32'd1);
            chk("bp_res0", u_if0.rsp_result, 32'd6);
            nxt();
        end
        u_if0.rsp_ready = 1'b1;
        @(negedge clk);
        chk("refill_rdy0", 32'(u_if0.req_ready), 32'd1);
        chk("refill_rdy1", 32'(u_if1.req_ready), 32'd0);
        nxt();
        u_if0.req_valid = 1'b0; u_if1.req_valid = 1'b0;
        @(negedge clk);
        chk("refill_vld0", 32'(u_if0.rsp_valid), 32'd1);
        chk("refill_res0", u_if0.rsp_result, 32'd6);
        nxt();

        // shift select passes through to the ALU
        u_if1.req_valid = 1'b1; u_if1.req_opA = 32'h8000_0000; u_if1.req_opB = 32'd4; u_if1.req_sel = 4'b1000;
        @(negedge clk);
        chk("sh_rdy1", 32'(u_if1.req_ready), 32'd1);
        chk("sh_alu_sel", 32'(alu_sel), 32'h8);
        chk("sh_alu_a", alu_opA, 32'h8000_0000);
        nxt();
        u_if1.req_valid = 1'b0;
        @(negedge clk);
        chk("sh_res1", u_if1.rsp_result, 32'h0800_0000);
        nxt();

        // reset right after a grant with requester 1 stalled
        u_if1.req_valid = 1'b1; u_if1.req_opA = 32'd1; u_if1.req_opB = 32'd2; u_if1.req_sel = 4'b0000;
        u_if1.rsp_ready = 1'b0;
        @(negedge clk);
        chk("mid_rdy1", 32'(u_if1.req_ready), 32'd1);
        nxt();
        rst = 1'b1;
        u_if0.req_valid = 1'b1; u_if0.req_opA = 32'd7; u_if0.req_opB = 32'd1; u_if0.req_sel = 4'b0000;
        @(negedge clk);
        chk("mid_vld1_pre", 32'(u_if1.rsp_valid), 32'd1);
        chk("mid_rst_rdy0", 32'(u_if0.req_ready), 32'd0);
        chk("mid_rst_rdy1", 32'(u_if1.req_ready), 32'd0);
        chk("mid_rst_alu_a", alu_opA, 32'd0);
        nxt();
        rst = 1'b0;
        u_if1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("mid_vld1_post", 32'(u_if1.rsp_valid), 32'd0);
        chk("mid_res1_post", u_if1.rsp_result, 32'd0);
        chk("mid_first_rdy0", 32'(u_if0.req_ready), 32'd1);
        chk("mid_first_rdy1", 32'(u_if1.req_ready), 32'd0);
        nxt();

        // idle: pointer must survive untouched
        u_if0.req_valid = 1'b0; u_if1.req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_rdy", 32'({u_if0.req_ready, u_if1.req_ready}), 32'd0);
            chk("idle_alu", alu_opA | alu_opB | 32'(alu_sel), 32'd0);
            nxt();
        end
        u_if0.req_valid = 1'b1; u_if1.req_valid = 1'b1;
        @(negedge clk);
        exp1 = !fixed;
        chk("post_idle_rdy0", 32'(u_if0.req_ready), 32'(!exp1));
        chk("post_idle_rdy1", 32'(u_if1.req_ready), 32'(exp1));
        nxt();
        u_if0.req_valid = 1'b0; u_if1.req_valid = 1'b0;
        repeat (3) nxt();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
